// File: rtl/risc15_pkg.sv
// Shared RISC15 pipeline constants: opcodes, NOP encoding, hazard FSM states.
package risc15_pkg;

  localparam logic [3:0]  OP_LW  = 4'b0100;
  localparam logic [3:0]  OP_LM  = 4'b0110;
  localparam logic [3:0]  OP_SM  = 4'b0111;

  localparam logic [15:0] NOP_IR = 16'hE000;

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_SEQ  = 1'b1;

  function automatic logic is_lmsm_op(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_pri_enc.sv
// Lowest-set-bit priority encoder for the LM/SM register bitmask.
module lmsm_pri_enc (
  input  logic [7:0] in_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  always_comb begin
    idx_o = 3'd0;
    any_o = |in_i;
    // Scan high to low so the lowest set bit is the last assignment.
    for (int i = 7; i >= 0; i--) begin
      if (in_i[i]) idx_o = i[2:0];
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: redirect flush, load-use stall, LM/SM micro-op sequencing
// and a saturating stall counter.
module pipeline_hazard_ctrl
  import risc15_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] id_ir,
  input  logic        id_valid,
  input  logic [2:0]  rr_src1,
  input  logic [2:0]  rr_src2,
  input  logic        rr_src1_vld,
  input  logic        rr_src2_vld,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_dest,
  input  logic        redirect,
  output logic        pc_write_n,
  output logic        pr1_write_n,
  output logic        pr2_write_n,
  output logic        pr3_write_n,
  output logic        pr4_write_n,
  output logic        pr1_nop,
  output logic        pr2_nop,
  output logic        pr3_nop,
  output logic        seq_valid,
  output logic [2:0]  seq_reg,
  output logic [2:0]  seq_offset,
  output logic [15:0] stall_count
);

  logic [0:0]  state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  offset_q, offset_d;
  logic [15:0] stall_cnt_q;

  logic        load_use;
  logic        id_lmsm;
  logic        in_seq;
  logic [7:0]  enc_in;
  logic [7:0]  enc_rem;
  logic [2:0]  enc_idx;
  logic        enc_any;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^id_ir[11:8];

  assign load_use = ex_is_load &
                    ((rr_src1_vld & (rr_src1 == ex_dest)) |
                     (rr_src2_vld & (rr_src2 == ex_dest)));
  assign id_lmsm  = id_valid & is_lmsm_op(id_ir[15:12]);
  assign in_seq   = (state_q == ST_SEQ);

  // In SEQ the decode-stage LM/SM is held, so the encoder works on the latched remainder.
  assign enc_in  = in_seq ? mask_q : id_ir[7:0];
  assign enc_rem = enc_in & ~(8'b1 << enc_idx);

  lmsm_pri_enc u_pri_enc (
    .in_i  (enc_in),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign pr4_write_n = 1'b0;
  assign stall_count = stall_cnt_q;

  always_comb begin
    pc_write_n  = 1'b0;
    pr1_write_n = 1'b0;
    pr2_write_n = 1'b0;
    pr3_write_n = 1'b0;
    pr1_nop     = 1'b0;
    pr2_nop     = 1'b0;
    pr3_nop     = 1'b0;
    seq_valid   = 1'b0;
    seq_reg     = 3'd0;
    seq_offset  = 3'd0;
    state_d     = state_q;
    mask_d      = mask_q;
    offset_d    = offset_q;

    if (reset) begin
      pr1_nop = 1'b1;
      pr2_nop = 1'b1;
      pr3_nop = 1'b1;
    end else if (redirect) begin
      pr1_nop  = 1'b1;
      pr2_nop  = 1'b1;
      state_d  = ST_IDLE;
      mask_d   = 8'd0;
      offset_d = 3'd0;
    end else if (load_use) begin
      // Sequencer state is frozen; the bubble in pr3 clears the hazard next cycle.
      pc_write_n  = 1'b1;
      pr1_write_n = 1'b1;
      pr2_write_n = 1'b1;
      pr3_nop     = 1'b1;
    end else if (in_seq) begin
      seq_valid  = 1'b1;
      seq_reg    = enc_idx;
      seq_offset = offset_q + 3'd1;
      offset_d   = offset_q + 3'd1;
      mask_d     = enc_rem;
      if (enc_rem != 8'd0) begin
        pc_write_n  = 1'b1;
        pr1_write_n = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (id_lmsm) begin
      if (enc_any) begin
        seq_valid  = 1'b1;
        seq_reg    = enc_idx;
        seq_offset = 3'd0;
        offset_d   = 3'd0;
        if (enc_rem != 8'd0) begin
          mask_d      = enc_rem;
          state_d     = ST_SEQ;
          pc_write_n  = 1'b1;
          pr1_write_n = 1'b1;
        end
      end else begin
        pr2_nop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mask_q      <= 8'd0;
      offset_q    <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      offset_q <= offset_d;
      if (pc_write_n && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] id_ir;
  logic        id_valid;
  logic [2:0]  rr_src1, rr_src2;
  logic        rr_src1_vld, rr_src2_vld;
  logic        ex_is_load;
  logic [2:0]  ex_dest;
  logic        redirect;
  logic        pc_write_n, pr1_write_n, pr2_write_n, pr3_write_n, pr4_write_n;
  logic        pr1_nop, pr2_nop, pr3_nop;
  logic        seq_valid;
  logic [2:0]  seq_reg, seq_offset;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_ir       (id_ir),
    .id_valid    (id_valid),
    .rr_src1     (rr_src1),
    .rr_src2     (rr_src2),
    .rr_src1_vld (rr_src1_vld),
    .rr_src2_vld (rr_src2_vld),
    .ex_is_load  (ex_is_load),
    .ex_dest     (ex_dest),
    .redirect    (redirect),
    .pc_write_n  (pc_write_n),
    .pr1_write_n (pr1_write_n),
    .pr2_write_n (pr2_write_n),
    .pr3_write_n (pr3_write_n),
    .pr4_write_n (pr4_write_n),
    .pr1_nop     (pr1_nop),
    .pr2_nop     (pr2_nop),
    .pr3_nop     (pr3_nop),
    .seq_valid   (seq_valid),
    .seq_reg     (seq_reg),
    .seq_offset  (seq_offset),
    .stall_count (stall_count)
  );

  // Output vector: {pc,pr1,pr2,pr3,pr4 write_n, pr1,pr2,pr3 nop, seq_valid, seq_reg, seq_offset}
  localparam logic [14:0] E_NORM = 15'b00000_000_0_000_000;
  localparam logic [14:0] E_RST  = 15'b00000_111_0_000_000;
  localparam logic [14:0] E_LU   = 15'b11100_001_0_000_000;
  localparam logic [14:0] E_RD   = 15'b00000_110_0_000_000;
  localparam logic [15:0] IR_NOP = 16'hE000;
  localparam logic [15:0] IR_ADD = 16'h0123;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: list of registers still to issue, last offset, stall count.
  int pend[$];
  int m_off = 0;
  int m_cnt = 0;

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic        iv;
    logic [2:0]  s1, s2;
    logic        v1, v2, ld;
    logic [2:0]  dst;
    logic        rd;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, act, exp);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic set_idle_inputs();
    reset = 1'b0; id_ir = IR_NOP; id_valid = 1'b0;
    rr_src1 = 3'd0; rr_src2 = 3'd0; rr_src1_vld = 1'b0; rr_src2_vld = 1'b0;
    ex_is_load = 1'b0; ex_dest = 3'd0; redirect = 1'b0;
  endtask

  // One clock: compare at negedge against the model (and optional hand value), then advance.
  task automatic tick(input bit do_chk, input string name, input bit use_hand, input logic [14:0] hand);
    int bits[$];
    int npend[$];
    int nm_off;
    int reg_v, off_v;
    bit pcw, p1w, p2w, n1, n2, n3, sv, lu, lmsm;
    logic [14:0] e, act;
    @(negedge clk);
    pcw = 0; p1w = 0; p2w = 0; n1 = 0; n2 = 0; n3 = 0; sv = 0; reg_v = 0; off_v = 0;
    lu = ex_is_load && ((rr_src1_vld && rr_src1 == ex_dest) || (rr_src2_vld && rr_src2 == ex_dest));
    lmsm = id_valid && (id_ir[15:12] == 4'b0110 || id_ir[15:12] == 4'b0111);
    for (int b = 0; b < 8; b++) if (id_ir[b]) bits.push_back(b);
    npend = pend;
    nm_off = m_off;
    if (reset) begin
      n1 = 1; n2 = 1; n3 = 1;
      npend.delete(); nm_off = 0;
    end else if (redirect) begin
      n1 = 1; n2 = 1;
      npend.delete(); nm_off = 0;
    end else if (lu) begin
      pcw = 1; p1w = 1; p2w = 1; n3 = 1;
    end else if (pend.size() > 0) begin
      sv = 1; reg_v = pend[0]; off_v = m_off + 1;
      if (pend.size() > 1) begin pcw = 1; p1w = 1; end
      void'(npend.pop_front());
      nm_off = m_off + 1;
    end else if (lmsm) begin
      if (bits.size() == 0) n2 = 1;
      else begin
        sv = 1; reg_v = bits[0]; off_v = 0;
        if (bits.size() > 1) begin pcw = 1; p1w = 1; end
        npend = bits;
        void'(npend.pop_front());
        nm_off = 0;
      end
    end
    e = {pcw, p1w, p2w, 1'b0, 1'b0, n1, n2, n3, sv, reg_v[2:0], off_v[2:0]};
    act = {pc_write_n, pr1_write_n, pr2_write_n, pr3_write_n, pr4_write_n,
           pr1_nop, pr2_nop, pr3_nop, seq_valid, seq_reg, seq_offset};
    if (do_chk) begin
      chk_vec({name, "_model"}, act, e);
      chk16({name, "_cnt"}, stall_count, m_cnt[15:0]);
    end
    if (use_hand) chk_vec(name, act, hand);
    pend = npend;
    m_off = nm_off;
    if (reset) m_cnt = 0;
    else if (pcw) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle_inputs();
    reset = 1'b1;
    tick(1, "reset", 1, E_RST);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, IR_ADD,  1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, E_RST};
    tbl[1]  = '{1'b0, IR_ADD,  1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, E_NORM};
    tbl[2]  = '{1'b0, IR_ADD,  1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, E_LU};
    tbl[3]  = '{1'b0, IR_ADD,  1'b1, 3'd3, 3'd5, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, E_NORM};
    tbl[4]  = '{1'b0, IR_ADD,  1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, E_NORM};
    tbl[5]  = '{1'b0, IR_ADD,  1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, E_RD};
    tbl[6]  = '{1'b0, IR_ADD,  1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, E_RD};
    tbl[7]  = '{1'b0, 16'h6010, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 15'b00000_000_1_100_000};
    tbl[8]  = '{1'b0, 16'h6000, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 15'b00000_010_0_000_000};
    tbl[9]  = '{1'b0, 16'h7080, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, E_NORM};
    tbl[10] = '{1'b0, 16'h6001, 1'b1, 3'd6, 3'd0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, E_NORM};
    tbl[11] = '{1'b0, 16'h7080, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 15'b00000_000_1_111_000};
    // Entry 10 has src2 valid on R0 vs ex_dest R6: no hazard, so the single-bit LM issues.
    tbl[10].exp = 15'b00000_000_1_000_000;

    set_idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; id_ir = tbl[i].ir; id_valid = tbl[i].iv;
      rr_src1 = tbl[i].s1; rr_src2 = tbl[i].s2; rr_src1_vld = tbl[i].v1; rr_src2_vld = tbl[i].v2;
      ex_is_load = tbl[i].ld; ex_dest = tbl[i].dst; redirect = tbl[i].rd;
      tick(1, $sformatf("tbl%0d", i), 1, tbl[i].exp);
    end

    // LM 1010_0101: four micro-ops, three stall cycles.
    do_reset();
    id_ir = 16'h60A5; id_valid = 1'b1;
    tick(1, "lm_a5_c1", 1, 15'b11000_000_1_000_000);
    tick(1, "lm_a5_c2", 1, 15'b11000_000_1_010_001);
    tick(1, "lm_a5_c3", 1, 15'b11000_000_1_101_010);
    tick(1, "lm_a5_c4", 1, 15'b00000_000_1_111_011);
    chk16("lm_a5_cnt", stall_count, 16'd3);
    id_ir = IR_NOP; id_valid = 1'b0;
    tick(1, "lm_a5_after", 1, E_NORM);

    // LW R3 in execute, consumer reads R3 as src2.
    id_ir = IR_ADD; id_valid = 1'b1;
    ex_is_load = 1'b1; ex_dest = 3'd3; rr_src2 = 3'd3; rr_src2_vld = 1'b1;
    tick(1, "lw_use", 1, E_LU);
    ex_is_load = 1'b0;
    tick(1, "lw_use_after", 1, E_NORM);
    set_idle_inputs();

    // SM 0x0F with redirect on the second micro-op; next cycle restarts from IDLE.
    do_reset();
    id_ir = 16'h700F; id_valid = 1'b1;
    tick(1, "sm_rd_c1", 1, 15'b11000_000_1_000_000);
    redirect = 1'b1;
    tick(1, "sm_rd_c2", 1, E_RD);
    redirect = 1'b0;
    tick(1, "sm_rd_idle", 1, 15'b11000_000_1_000_000);

    // LM with empty mask.
    do_reset();
    id_ir = 16'h6000; id_valid = 1'b1;
    tick(1, "lm_zero", 1, 15'b00000_010_0_000_000);
    id_ir = IR_NOP; id_valid = 1'b0;
    tick(1, "lm_zero_after", 1, E_NORM);

    // LM 0x07 with a load-use in its second cycle.
    id_ir = 16'h6007; id_valid = 1'b1;
    tick(1, "lm7_c1", 1, 15'b11000_000_1_000_000);
    ex_is_load = 1'b1; ex_dest = 3'd5; rr_src1 = 3'd5; rr_src1_vld = 1'b1;
    tick(1, "lm7_lu", 1, E_LU);
    ex_is_load = 1'b0;
    tick(1, "lm7_c3", 1, 15'b11000_000_1_001_001);
    tick(1, "lm7_c4", 1, 15'b00000_000_1_010_010);
    set_idle_inputs();

    // Saturation: a held load-use stall pushes the counter to FFFE.
    do_reset();
    ex_is_load = 1'b1; ex_dest = 3'd2; rr_src1 = 3'd2; rr_src1_vld = 1'b1;
    for (int i = 0; i < 65534; i++) tick(0, "sat", 0, E_NORM);
    chk16("sat_fffe", stall_count, 16'hFFFE);
    set_idle_inputs();
    id_ir = 16'h60FF; id_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick(1, $sformatf("sat_lm%0d", i), 0, E_NORM);
    chk16("sat_hold", stall_count, 16'hFFFF);

    // Reset in the middle of a sequence abandons it.
    tick(1, "rst_seq_c1", 1, 15'b11000_000_1_000_000);
    tick(1, "rst_seq_c2", 1, 15'b11000_000_1_001_001);
    reset = 1'b1;
    tick(1, "rst_seq_rst", 1, E_RST);
    reset = 1'b0; id_ir = IR_NOP; id_valid = 1'b0;
    tick(1, "rst_seq_after", 1, E_NORM);
    chk16("rst_seq_cnt", stall_count, 16'd0);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] m;
      reset = ($urandom_range(0, 49) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: m = 8'd0;
        1: m = 8'b1 << $urandom_range(0, 7);
        default: m = 8'($urandom);
      endcase
      id_ir = {(r == 0) ? 4'b0110 : (r == 1) ? 4'b0111 : 4'($urandom_range(0, 5)), 4'($urandom), m};
      rr_src1 = 3'($urandom_range(0, 3)); rr_src2 = 3'($urandom_range(0, 3));
      rr_src1_vld = 1'($urandom); rr_src2_vld = 1'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_dest = 3'($urandom_range(0, 3));
      redirect = ($urandom_range(0, 11) == 0);
      tick(1, $sformatf("rnd%0d", i), 0, E_NORM);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_ir  in  16  instruction in the decode stage; opcode is [15:12], LM=0110, SM=0111, bitmask is [7:0].
REQ-005 id_valid  in  1  id_ir is a real instruction, not a NOP bubble.
REQ-006 rr_src1, rr_src2  in  3 each  source registers of the register-read-stage instruction.
REQ-007 rr_src1_vld, rr_src2_vld  in  1 each  the matching source is actually read.
REQ-008 ex_is_load  in  1  the execute-stage instruction is LW or an LM micro-op.
REQ-009 ex_dest  in  3  destination register of the execute-stage instruction.
REQ-010 redirect  in  1  a taken branch or jump was resolved in execute this cycle.
REQ-011 pc_write_n, pr1_write_n, pr2_write_n, pr3_write_n, pr4_write_n  out  1 each  active-low capture enables; 0 = capture.
REQ-012 pr1_nop, pr2_nop, pr3_nop  out  1 each  the named pipeline register loads the NOP encoding on the next edge.
REQ-013 seq_valid  out  1  an LM/SM micro-op is being issued this cycle.
REQ-014 seq_reg  out  3  register index of the current micro-op.
REQ-015 seq_offset  out  3  the micro-op's ordinal within its LM/SM: 0 for the first, 1 for the second, and so on.
REQ-016 stall_count  out  16  saturating count of cycles in which pc_write_n=1.

Function
REQ-017 The write-enable and NOP outputs SHALL be combinational functions of the current state and the current inputs.
REQ-018 pr4_write_n SHALL be 0 at all times.
REQ-019 Priority SHALL be redirect, then load-use stall, then LM/SM sequencing, then normal flow.
REQ-020 Normal flow: all write_n=0, all nop=0, seq_valid=0.
REQ-021 Redirect: pc_write_n=0 and pr1_nop=pr2_nop=1; FSM SHALL return to IDLE and the mask register SHALL clear on the same edge.
REQ-022 Load-use is ex_is_load & ((rr_src1_vld & rr_src1==ex_dest) | (rr_src2_vld & rr_src2==ex_dest)).
REQ-023 Load-use stall: pc/pr1/pr2 write_n=1 and pr3_nop=1, lasting exactly 1 cycle because the injected bubble clears the condition.
REQ-024 During a load-use stall the LM/SM FSM SHALL hold its state, mask and offset unchanged.
REQ-025 FSM states SHALL be IDLE and SEQ.
REQ-026 IDLE, LM/SM in decode (id_valid & opcode LM/SM), mask M: seq_valid=1, seq_reg=lowest set bit of M, seq_offset=0.
REQ-027 IDLE, M with 2 or more bits set: remaining mask (M with that bit cleared) SHALL be latched, FSM goes to SEQ, and pc_write_n=pr1_write_n=1.
REQ-028 IDLE, M with exactly 1 bit set: one micro-op, no stall, FSM stays IDLE.
REQ-029 IDLE, M=0: seq_valid=0, no stall; the instruction passes as a NOP (pr2_nop=1).
REQ-030 SEQ: seq_reg SHALL be the lowest set bit of the latched mask, seq_offset SHALL be the previous offset+1, and that bit SHALL clear.
REQ-031 SEQ: pc/pr1 stay stalled while more than one bit remains; on the last bit the FSM returns to IDLE with no stall.
REQ-032 An N-bit mask SHALL take exactly N cycles of seq_valid and N-1 stall cycles.
REQ-033 stall_count SHALL increment on every edge where pc_write_n=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-034 On a reset edge: FSM=IDLE, mask=0, offset=0, stall_count=0.
REQ-035 While reset=1: all write_n=0, all nop=1, seq_valid=0, seq_reg=0, seq_offset=0.
REQ-036 Reset mid-sequence SHALL abandon the sequence, with no further micro-ops issued.

Structure
REQ-037 Opcode constants (LW, LM, SM), the NOP encoding and the FSM state encoding SHALL live in the shared package risc15_pkg.
REQ-038 Lowest-set-bit selection SHALL be one combinational sub-module, lmsm_pri_enc, with 8-bit in, 3-bit index out and a 1-bit any/none flag.

Verification
REQ-039 LM, mask 8'b1010_0101, no hazards -> seq_reg 0,2,5,7; offsets 0,1,2,3; pc_write_n=1 for 3 cycles; stall_count=3.
REQ-040 LW R3 in execute, rr_src2=3 with rr_src2_vld=1 -> 1 cycle with pc/pr1/pr2 write_n=1 and pr3_nop=1; next cycle normal.
REQ-041 SM, mask 8'h0F, redirect on the 2nd micro-op cycle -> pr1_nop=pr2_nop=1, IDLE next cycle, no 3rd micro-op.
REQ-042 LM, mask 8'h00 -> seq_valid never 1, no stall, pr2_nop=1 for one cycle.
REQ-043 Load-use in the 2nd cycle of LM mask 8'h07 -> sequence pauses 1 cycle, then resumes at seq_reg=1, offset=1.
REQ-044 stall_count preloaded to 16'hFFFE via a long stall sequence -> holds at 16'hFFFF; reset mid-SEQ -> seq_valid=0 on the following cycle.
